// File: rtl/memory_stage.sv
// Memory stage of the RV32I pipeline: EX/MEM register, byte-lane store port,
// load extraction/extension and misaligned/illegal access detection.
module memory_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] ALUResultE_i,
    input  logic [DATA_WIDTH-1:0] WriteDataE_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
    input  logic [4:0]            RdE_i,
    input  logic                  RegWriteE_i,
    input  logic [1:0]            ResultSrcE_i,
    input  logic                  MemWriteE_i,
    input  logic [2:0]            Funct3E_i,
    input  logic                  StallM_i,
    input  logic                  FlushM_i,
    input  logic [DATA_WIDTH-1:0] DMemRData_i,
    output logic [DATA_WIDTH-1:0] DMemAddr_o,
    output logic [DATA_WIDTH-1:0] DMemWData_o,
    output logic [3:0]            DMemByteEn_o,
    output logic                  DMemWE_o,
    output logic [DATA_WIDTH-1:0] ALUResultM_o,
    output logic [DATA_WIDTH-1:0] ReadDataM_o,
    output logic [DATA_WIDTH-1:0] PCPlus4M_o,
    output logic [4:0]            RdM_o,
    output logic                  RegWriteM_o,
    output logic [1:0]            ResultSrcM_o,
    output logic                  MisalignM_o
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [DATA_WIDTH-1:0] alu_result_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic [DATA_WIDTH-1:0] pc_plus4_q;
    logic [4:0]            rd_q;
    logic                  reg_write_q;
    logic [1:0]            result_src_q;
    logic                  mem_write_q;
    logic [2:0]            funct3_q;

    // Reset and flush both produce an all-zero bubble; flush beats stall.
    always_ff @(posedge clk_i) begin
        if (rst_i || FlushM_i) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            mem_write_q  <= 1'b0;
            funct3_q     <= '0;
        end else if (!StallM_i) begin
            alu_result_q <= ALUResultE_i;
            write_data_q <= WriteDataE_i;
            pc_plus4_q   <= PCPlus4E_i;
            rd_q         <= RdE_i;
            reg_write_q  <= RegWriteE_i;
            result_src_q <= ResultSrcE_i;
            mem_write_q  <= MemWriteE_i;
            funct3_q     <= Funct3E_i;
        end
    end

    logic [1:0] addr_lo;
    logic       is_load;
    logic       access;
    logic       legal;
    logic       bad_align;
    logic       misalign;

    assign addr_lo = alu_result_q[1:0];
    assign is_load = (result_src_q == 2'b01);
    assign access  = mem_write_q | is_load;

    // A store with ResultSrc=01 is judged by the store funct3 table.
    always_comb begin
        legal     = 1'b0;
        bad_align = 1'b0;
        if (mem_write_q) begin
            legal = (funct3_q == F3_B) || (funct3_q == F3_H) || (funct3_q == F3_W);
        end else begin
            legal = (funct3_q == F3_B) || (funct3_q == F3_H) || (funct3_q == F3_W) ||
                    (funct3_q == F3_BU) || (funct3_q == F3_HU);
        end
        case (funct3_q[1:0])
            2'b01:   bad_align = addr_lo[0];
            2'b10:   bad_align = |addr_lo;
            default: bad_align = 1'b0;
        endcase
        misalign = access & (~legal | bad_align);
    end

    logic [3:0]            store_be;
    logic [DATA_WIDTH-1:0] store_wdata;

    always_comb begin
        store_be    = 4'b0000;
        store_wdata = write_data_q;
        case (funct3_q[1:0])
            2'b00: begin
                store_be    = 4'b0001 << addr_lo;
                store_wdata = {4{write_data_q[7:0]}};
            end
            2'b01: begin
                store_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{write_data_q[15:0]}};
            end
            2'b10:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    end

    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        case (addr_lo)
            2'd0:    load_byte = DMemRData_i[7:0];
            2'd1:    load_byte = DMemRData_i[15:8];
            2'd2:    load_byte = DMemRData_i[23:16];
            default: load_byte = DMemRData_i[31:24];
        endcase
        load_half = addr_lo[1] ? DMemRData_i[31:16] : DMemRData_i[15:0];
        case (funct3_q)
            F3_B:    load_ext = {{24{load_byte[7]}}, load_byte};
            F3_H:    load_ext = {{16{load_half[15]}}, load_half};
            F3_W:    load_ext = DMemRData_i;
            F3_BU:   load_ext = {24'd0, load_byte};
            F3_HU:   load_ext = {16'd0, load_half};
            default: load_ext = '0;
        endcase
    end

    assign DMemWE_o     = mem_write_q & ~misalign;
    assign DMemByteEn_o = DMemWE_o ? store_be : 4'b0000;
    assign DMemAddr_o   = {alu_result_q[DATA_WIDTH-1:2], 2'b00};
    assign DMemWData_o  = store_wdata;
    assign ReadDataM_o  = (is_load && !misalign) ? load_ext : '0;
    assign RegWriteM_o  = reg_write_q & ~misalign;
    assign MisalignM_o  = misalign;
    assign ALUResultM_o = alu_result_q;
    assign PCPlus4M_o   = pc_plus4_q;
    assign RdM_o        = rd_q;
    assign ResultSrcM_o = result_src_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, stores, load extension, misalignment,
// stall/flush priority and back-to-back traffic against a small memory model.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_e, wd_e, pc4_e;
    logic [4:0]  rd_e;
    logic        regw_e;
    logic [1:0]  rsrc_e;
    logic        memw_e;
    logic [2:0]  f3_e;
    logic        stall, flush;
    logic [31:0] rdata;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_we;
    logic [31:0] alu_m, rd_data_m, pc4_m;
    logic [4:0]  rd_m;
    logic        regw_m;
    logic [1:0]  rsrc_m;
    logic        misalign_m;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: forced read word for extraction tests, otherwise an array.
    logic [31:0] mem [0:63];
    logic        force_rd;
    logic [31:0] force_val;
    logic [38:0] exp_q [$];

    memory_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ALUResultE_i (alu_e),
        .WriteDataE_i (wd_e),
        .PCPlus4E_i   (pc4_e),
        .RdE_i        (rd_e),
        .RegWriteE_i  (regw_e),
        .ResultSrcE_i (rsrc_e),
        .MemWriteE_i  (memw_e),
        .Funct3E_i    (f3_e),
        .StallM_i     (stall),
        .FlushM_i     (flush),
        .DMemRData_i  (rdata),
        .DMemAddr_o   (dmem_addr),
        .DMemWData_o  (dmem_wdata),
        .DMemByteEn_o (dmem_be),
        .DMemWE_o     (dmem_we),
        .ALUResultM_o (alu_m),
        .ReadDataM_o  (rd_data_m),
        .PCPlus4M_o   (pc4_m),
        .RdM_o        (rd_m),
        .RegWriteM_o  (regw_m),
        .ResultSrcM_o (rsrc_m),
        .MisalignM_o  (misalign_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb rdata = force_rd ? force_val : mem[dmem_addr[7:2]];

    always @(posedge clk) begin
        if (dmem_we) begin
            for (int b = 0; b < 4; b++)
                if (dmem_be[b]) mem[dmem_addr[7:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic regw, input logic [1:0] rsrc,
                         input logic memw, input logic [2:0] f3);
        alu_e = alu; wd_e = wd; pc4_e = pc4; rd_e = rd;
        regw_e = regw; rsrc_e = rsrc; memw_e = memw; f3_e = f3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_m(input string tag);
        logic [38:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_alu"},  alu_m,          e[38:7]);
            check({tag, "_rd"},   {27'd0, rd_m},  {27'd0, e[6:2]});
            check({tag, "_rsrc"}, {30'd0, rsrc_m}, {30'd0, e[1:0]});
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        force_rd = 1'b0; force_val = 32'd0;
        stall = 1'b0; flush = 1'b0;
        rst = 1'b1;
        drive(32'h10, 32'hDEADBEEF, 32'h8, 5'd1, 1'b1, 2'b00, 1'b1, 3'b010);

        // Reset held two cycles with a sw pending on the inputs
        step();
        check("rst1_we", {31'd0, dmem_we}, 32'd0);
        step();
        check("rst2_we",    {31'd0, dmem_we},    32'd0);
        check("rst_alu",    alu_m,               32'd0);
        check("rst_addr",   dmem_addr,           32'd0);
        check("rst_wdata",  dmem_wdata,          32'd0);
        check("rst_be",     {28'd0, dmem_be},    32'd0);
        check("rst_rdata",  rd_data_m,           32'd0);
        check("rst_pc4",    pc4_m,               32'd0);
        check("rst_rd",     {27'd0, rd_m},       32'd0);
        check("rst_regw",   {31'd0, regw_m},     32'd0);
        check("rst_rsrc",   {30'd0, rsrc_m},     32'd0);
        check("rst_mis",    {31'd0, misalign_m}, 32'd0);
        rst = 1'b0;

        // sb at 0x1003
        drive(32'h1003, 32'hAABBCCDD, 32'h104, 5'd0, 1'b0, 2'b00, 1'b1, 3'b000);
        step();
        check("sb_be",    {28'd0, dmem_be}, 32'h8);
        check("sb_wdata", dmem_wdata,       32'hDDDDDDDD);
        check("sb_we",    {31'd0, dmem_we}, 32'd1);
        check("sb_addr",  dmem_addr,        32'h1000);
        check("sb_mis",   {31'd0, misalign_m}, 32'd0);

        // sh at 0x1006 selects the upper half
        drive(32'h1006, 32'h1234ABCD, 32'h108, 5'd0, 1'b0, 2'b00, 1'b1, 3'b001);
        step();
        check("sh_be",    {28'd0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata,       32'hABCDABCD);

        // Loads from 0x2002 with a fixed read word
        force_rd = 1'b1; force_val = 32'h80F17F00;
        drive(32'h2002, 32'h0, 32'h10C, 5'd7, 1'b1, 2'b01, 1'b0, 3'b000);
        step();
        check("lb",       rd_data_m,        32'hFFFFFFF1);
        check("lb_regw",  {31'd0, regw_m},  32'd1);
        check("lb_we",    {31'd0, dmem_we}, 32'd0);
        f3_e = 3'b100; step();
        check("lbu", rd_data_m, 32'h000000F1);
        f3_e = 3'b001; step();
        check("lh",  rd_data_m, 32'hFFFF80F1);
        f3_e = 3'b101; step();
        check("lhu", rd_data_m, 32'h000080F1);

        // Misaligned / illegal accesses
        drive(32'h3001, 32'h55555555, 32'h110, 5'd0, 1'b0, 2'b00, 1'b1, 3'b010);
        step();
        check("sw_mis",    {31'd0, misalign_m}, 32'd1);
        check("sw_mis_we", {31'd0, dmem_we},    32'd0);
        check("sw_mis_be", {28'd0, dmem_be},    32'd0);
        drive(32'h3002, 32'h0, 32'h114, 5'd6, 1'b1, 2'b01, 1'b0, 3'b010);
        step();
        check("lw_mis",       {31'd0, misalign_m}, 32'd1);
        check("lw_mis_regw",  {31'd0, regw_m},     32'd0);
        check("lw_mis_rdata", rd_data_m,           32'd0);
        drive(32'h3000, 32'h0, 32'h118, 5'd0, 1'b0, 2'b00, 1'b1, 3'b100);
        step();
        check("st_f3_ill",    {31'd0, misalign_m}, 32'd1);
        check("st_f3_ill_we", {31'd0, dmem_we},    32'd0);

        // Stall holds, flush beats stall
        drive(32'h2000, 32'h0, 32'h104, 5'd9, 1'b1, 2'b01, 1'b0, 3'b010);
        step();
        check("lw_alu",   alu_m,     32'h2000);
        check("lw_rdata", rd_data_m, 32'h80F17F00);
        stall = 1'b1;
        drive(32'h55, 32'h0, 32'h200, 5'd3, 1'b1, 2'b00, 1'b0, 3'b000);
        step();
        step();
        check("stall_alu",  alu_m,           32'h2000);
        check("stall_rd",   {27'd0, rd_m},   32'd9);
        check("stall_pc4",  pc4_m,           32'h104);
        check("stall_rsrc", {30'd0, rsrc_m}, 32'd1);
        check("stall_regw", {31'd0, regw_m}, 32'd1);
        flush = 1'b1;
        step();
        check("flush_regw", {31'd0, regw_m}, 32'd0);
        check("flush_rd",   {27'd0, rd_m},   32'd0);
        check("flush_alu",  alu_m,           32'd0);
        flush = 1'b0; stall = 1'b0;

        // Reset wins over stall mid-stream
        drive(32'h44, 32'h1, 32'h300, 5'd0, 1'b0, 2'b00, 1'b1, 3'b010);
        step();
        check("pre_rst_we", {31'd0, dmem_we}, 32'd1);
        rst = 1'b1; stall = 1'b1;
        step();
        check("mid_rst_we",  {31'd0, dmem_we}, 32'd0);
        check("mid_rst_alu", alu_m,            32'd0);
        rst = 1'b0; stall = 1'b0;

        // Back-to-back: sw, lw, add through the memory model
        force_rd = 1'b0;
        drive(32'h40, 32'h11223344, 32'h400, 5'd0, 1'b0, 2'b00, 1'b1, 3'b010);
        exp_q.push_back({32'h40, 5'd0, 2'b00});
        step();
        check_m("b2b_sw");
        check("b2b_sw_we", {31'd0, dmem_we}, 32'd1);
        drive(32'h40, 32'h0, 32'h404, 5'd4, 1'b1, 2'b01, 1'b0, 3'b010);
        exp_q.push_back({32'h40, 5'd4, 2'b01});
        step();
        check_m("b2b_lw");
        check("b2b_lw_data", rd_data_m, 32'h11223344);
        drive(32'h99, 32'h0, 32'h408, 5'd5, 1'b1, 2'b00, 1'b0, 3'b000);
        exp_q.push_back({32'h99, 5'd5, 2'b00});
        step();
        check_m("b2b_add");
        check("b2b_add_regw",  {31'd0, regw_m}, 32'd1);
        check("b2b_add_rdata", rd_data_m,       32'd0);
        check("b2b_add_pc4",   pc4_m,           32'h408);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the five-stage RV32I pipeline, directly downstream of the execute stage. Contains the EX/MEM pipeline register; drives the byte-lane data-memory port for stores; extracts and sign/zero-extends load data; detects misaligned or illegal accesses. Feeds the writeback stage and returns `ALUResultM_o` to execute for forwarding.

## Interface
- `DATA_WIDTH`, default 32, datapath width (design supports only 32)
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  synchronous reset, active-high
- `ALUResultE_i`  in  32  execute ALU result (memory address for loads/stores)
- `WriteDataE_i`  in  32  forwarded rs2 value (store data)
- `PCPlus4E_i`  in  32  PC+4 of the instruction in execute
- `RdE_i`  in  5  destination register
- `RegWriteE_i`  in  1  register write enable
- `ResultSrcE_i`  in  2  result select: 00 ALU, 01 load data, 10 PC+4
- `MemWriteE_i`  in  1  store enable
- `Funct3E_i`  in  3  access size/sign
- `StallM_i`  in  1  hold the EX/MEM register
- `FlushM_i`  in  1  load a bubble into the EX/MEM register
- `DMemRData_i`  in  32  data-memory read word (combinational read of `DMemAddr_o`)
- `DMemAddr_o`  out  32  word-aligned address: `{ALUResultM[31:2],2'b00}`
- `DMemWData_o`  out  32  lane-replicated store data
- `DMemByteEn_o`  out  4  byte-lane enables
- `DMemWE_o`  out  1  write enable (memory commits on the rising edge)
- `ALUResultM_o`  out  32  registered ALU result (to writeback and execute forwarding)
- `ReadDataM_o`  out  32  extended load data
- `PCPlus4M_o`  out  32  registered PC+4
- `RdM_o`  out  5  registered destination register (to hazard unit)
- `RegWriteM_o`  out  1  register write enable, after suppression
- `ResultSrcM_o`  out  2  registered result select
- `MisalignM_o`  out  1  access in the memory stage is misaligned or illegal

## Operation
- EX/MEM register fields: ALUResult, WriteData, PCPlus4, Rd, RegWrite, ResultSrc, MemWrite, Funct3.
- Update priority at each edge: `rst_i` > `FlushM_i` > `StallM_i` > load from the E inputs.
- Reset and flush both clear every field to 0, giving a bubble with no write and no register write.
- Stall holds all fields unchanged.
- Access = `MemWriteM` or (`ResultSrcM==01`).
- Legal funct3 values:
  - Stores: 000 sb, 001 sh, 010 sw.
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- `MisalignM_o` = access AND any of:
  - funct3 not legal for its kind;
  - halfword with `addr[0]=1`;
  - word with `addr[1:0]!=00`.
- Store byte enables:
  - sb: `0001<<addr[1:0]`;
  - sh: `0011<<{addr[1],1'b0}`;
  - sw: `1111`.
- Store write data:
  - sb: `{4{wd[7:0]}}`;
  - sh: `{2{wd[15:0]}}`;
  - sw: `wd`.
- `DMemWE_o = MemWriteM & ~MisalignM_o`. When `DMemWE_o=0`, `DMemByteEn_o=0000`.
- Load extraction:
  - byte = `RData[8*addr[1:0] +: 8]`;
  - half = `RData[16*addr[1] +: 16]`;
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- `ReadDataM_o` = 0 when the instruction is not a load or is misaligned.
- `RegWriteM_o = RegWriteM & ~MisalignM_o`. Trap handling is outside this block.

## Timing
- Latency: one cycle. Values present on the E inputs before edge N appear on the M outputs after edge N.
- All memory-port outputs and `ReadDataM_o` are combinational from the register and `DMemRData_i`. There is no extra cycle for loads; the memory read is asynchronous.
- A store is committed by the memory on the edge that ends its M cycle.
- A stalled store keeps `DMemWE_o` high. Rewriting the same data is idempotent and allowed.
- Reset values of all outputs: 0, including `DMemAddr_o`, `DMemByteEn_o`, `DMemWE_o`, `MisalignM_o`, `RegWriteM_o` and `ResultSrcM_o`.
- Reset asserted mid-stream: the next cycle is a bubble regardless of flush/stall.
- Simultaneous flush and stall: flush wins.

## Test plan
- **Reset:** hold `rst_i` 2 cycles with a sw on the inputs → all outputs 0, `DMemWE_o=0` throughout.
- **sb at addr 0x1003, wd=0xAABBCCDD** → next cycle `DMemByteEn_o=1000`, `DMemWData_o=0xDDDDDDDD`, `DMemWE_o=1`, `DMemAddr_o=0x1000`.
- **Loads, addr 0x2002, `DMemRData_i=0x80F17F00`:**
  - lb → `0xFFFFFFF1`;
  - lbu → `0x000000F1`;
  - lh → `0xFFFF80F1`;
  - lhu → `0x000080F1`.
- **Misaligned accesses:**
  - sw at 0x3001 → `MisalignM_o=1`, `DMemWE_o=0`, `DMemByteEn_o=0000`;
  - lw at 0x3002 with `RegWriteE_i=1` → `RegWriteM_o=0`, `ReadDataM_o=0`.
- **Stall/flush:**
  - lw loaded, then `StallM_i=1` for 2 cycles with new inputs → M outputs unchanged;
  - then `FlushM_i=StallM_i=1` → bubble (`RegWriteM_o=0`, `RdM_o=0`).
- **Back-to-back traffic:** sw 0x11223344 @0x40, lw @0x40, add to Rd=5 → `ALUResultM_o`, `RdM_o` and `ResultSrcM_o` track each instruction one cycle later; with a memory model, the lw returns 0x11223344.
